// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus handshake sequencer that feeds the UART transmitter one frame at a time.
// Optional frame-completion watchdog enabled with `define UART_TX_TIMEOUT_EN.
module uart_tx_feeder #(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        WR_DATA,
    input  logic              WR_EN,
    output logic              FULL,
    output logic              EMPTY,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERFLOW,
    output logic              BUSY,
    output logic [7:0]        TX_DATA,
    output logic              TX_CAPTURE,
    output logic              TX_TRANSMIT,
    input  logic              TX_SENT,
    output logic              TX_ACK,
    output logic              TIMEOUT_ERR
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_ACK} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    generate
        if (DEPTH != (1 << ADDR_W) || DEPTH < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 16383) begin : g_bad_cfg
            $error("uart_tx_feeder: inconsistent DEPTH/ADDR_W/TIMEOUT_CYCLES");
        end
    endgenerate

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q;
    state_t            state_q, state_d;
    logic [7:0]        txd_q, txd_d;
    logic              cap_q, cap_d;
    logic              ack_q, ack_d;
    logic              wr_acc, pop, full, empty;

    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    // FULL is taken from the registered count, so a pop in the same cycle does not rescue a write.
    assign wr_acc = WR_EN && !full;
    assign pop    = (state_q == S_LOAD);

    always_comb begin
        count_d = count_q;
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) mem[wr_ptr_q] <= WR_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (WR_EN && full) ovf_q <= 1'b1;
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    localparam logic [13:0] TMO_LAST = 14'(TIMEOUT_CYCLES - 1);
    logic [13:0] tmo_q, tmo_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        txd_d   = txd_q;
        cap_d   = 1'b0;
        ack_d   = 1'b0;
`ifdef UART_TX_TIMEOUT_EN
        tmo_d   = '0;
        err_d   = err_q;
`endif
        case (state_q)
            // A TX_SENT still high from the previous frame holds off the next load.
            S_IDLE: if (!empty && !TX_SENT) begin
                state_d = S_LOAD;
                txd_d   = mem[rd_ptr_q];
                cap_d   = 1'b1;
            end
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                if (TX_SENT) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                end
`ifdef UART_TX_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            txd_q   <= 8'h00;
            cap_q   <= 1'b0;
            ack_q   <= 1'b0;
`ifdef UART_TX_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            txd_q   <= txd_d;
            cap_q   <= cap_d;
            ack_q   <= ack_d;
`ifdef UART_TX_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    assign TIMEOUT_ERR = err_q;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

    assign FULL        = full;
    assign EMPTY       = empty;
    assign COUNT       = count_q;
    assign OVERFLOW    = ovf_q;
    assign BUSY        = (state_q != S_IDLE) || !empty;
    assign TX_DATA     = txd_q;
    assign TX_CAPTURE  = cap_q;
    assign TX_TRANSMIT = cap_q;
    assign TX_ACK      = ack_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: latency, burst/full/overflow, write+pop, mid-frame reset.
module tb_uart_tx_feeder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] WR_DATA = 8'h00;
    logic       WR_EN = 1'b0;
    logic       TX_SENT = 1'b0;
    logic       FULL, EMPTY, OVERFLOW, BUSY, TX_CAPTURE, TX_TRANSMIT, TX_ACK, TIMEOUT_ERR;
    logic [4:0] COUNT;
    logic [7:0] TX_DATA;

    int checks = 0;
    int errors = 0;

    uart_tx_feeder dut (
        .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
        .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW), .BUSY(BUSY),
        .TX_DATA(TX_DATA), .TX_CAPTURE(TX_CAPTURE), .TX_TRANSMIT(TX_TRANSMIT),
        .TX_SENT(TX_SENT), .TX_ACK(TX_ACK), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        WR_EN = 1'b1;
        WR_DATA = d;
        tick();
        WR_EN = 1'b0;
    endtask

    // Wait for the LOAD pulse, check it, step into WAIT_SENT. gap = cycles waited.
    task automatic load_chk(input logic [7:0] exp, output int gap);
        gap = 0;
        while (!TX_TRANSMIT && gap < 20) begin
            tick();
            gap++;
        end
        chk("load_seen", TX_TRANSMIT, 1);
        chk("load_cap", TX_CAPTURE, 1);
        chk("load_data", TX_DATA, exp);
        tick();
    endtask

    // Transmitter model: hold frame w cycles, raise TX_SENT, expect one-cycle ACK.
    task automatic finish(input int w);
        int early = 0;
        repeat (w) begin
            tick();
            if (TX_ACK) early++;
        end
        chk("ack_early", early, 0);
        TX_SENT = 1'b1;
        tick();
        chk("ack_hi", TX_ACK, 1);
        TX_SENT = 1'b0;
        tick();
        chk("ack_lo", TX_ACK, 0);
    endtask

    initial begin
        int gap;
        int spur;
        tick();
        tick();
        chk("rst_count", COUNT, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_ovf", OVERFLOW, 0);
        chk("rst_txd", TX_DATA, 8'h00);
        chk("rst_cap", TX_CAPTURE, 0);
        chk("rst_ack", TX_ACK, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_terr", TIMEOUT_ERR, 0);
        RST = 1'b0;
        tick();

        // Stray TX_SENT with nothing in flight
        TX_SENT = 1'b1;
        spur = 0;
        repeat (3) begin tick(); if (TX_ACK) spur++; end
        TX_SENT = 1'b0;
        tick();
        chk("idle_sent_noack", spur, 0);

        // Single byte latency
        wr(8'hA5);
        chk("a5_empty", EMPTY, 0);
        chk("a5_count", COUNT, 1);
        chk("a5_notyet", TX_TRANSMIT, 0);
        tick();
        chk("a5_cap", TX_CAPTURE, 1);
        chk("a5_trn", TX_TRANSMIT, 1);
        chk("a5_data", TX_DATA, 8'hA5);
        chk("a5_busy", BUSY, 1);
        tick();
        chk("a5_cap_off", TX_CAPTURE, 0);
        chk("a5_pop", COUNT, 0);
        finish(8668);
        chk("a5_done_empty", EMPTY, 1);
        chk("a5_done_busy", BUSY, 0);
        chk("a5_terr", TIMEOUT_ERR, 0);

        // Burst 01..10; 01 is popped during the burst
        for (int i = 1; i <= 16; i++) begin
            wr(8'(i));
            if (i == 1) chk("b_cnt1", COUNT, 1);
            if (i == 2) chk("b_cnt2", COUNT, 2);
            if (i == 3) chk("b_cnt3_wrpop", COUNT, 2);
        end
        chk("b_cnt15", COUNT, 15);
        chk("b_txd01", TX_DATA, 8'h01);
        wr(8'h11);
        chk("b_full", FULL, 1);
        chk("b_cnt16", COUNT, 16);
        chk("b_ovf0", OVERFLOW, 0);
        wr(8'hFF);
        chk("ovf_set", OVERFLOW, 1);
        chk("ovf_cnt", COUNT, 16);
        finish(3);
        for (int b = 2; b <= 17; b++) begin
            load_chk(8'(b), gap);
            if (b == 2) chk("b2b_gap", gap, 1);
            finish(3);
        end
        chk("b_empty", EMPTY, 1);
        chk("b_busy", BUSY, 0);
        chk("b_ovf_sticky", OVERFLOW, 1);

        // Write coinciding with LOAD pop at COUNT=5
        for (int i = 0; i < 6; i++) wr(8'h21 + 8'(i));
        chk("wp_cnt5", COUNT, 5);
        finish(2);
        tick();
        chk("wp_load", TX_TRANSMIT, 1);
        chk("wp_data", TX_DATA, 8'h22);
        chk("wp_pre", COUNT, 5);
        wr(8'h27);
        chk("wp_post", COUNT, 5);
        finish(2);
        for (int b = 8'h23; b <= 8'h27; b++) begin
            load_chk(8'(b), gap);
            finish(2);
        end
        chk("wp_empty", EMPTY, 1);

        // Reset mid-frame with 3 queued
        for (int i = 0; i < 4; i++) wr(8'h31 + 8'(i));
        chk("mr_cnt3", COUNT, 3);
        chk("mr_txd", TX_DATA, 8'h31);
        RST = 1'b1;
        tick();
        chk("mr_count", COUNT, 0);
        chk("mr_empty", EMPTY, 1);
        chk("mr_full", FULL, 0);
        chk("mr_ovf", OVERFLOW, 0);
        chk("mr_txd0", TX_DATA, 8'h00);
        chk("mr_cap", TX_CAPTURE, 0);
        chk("mr_trn", TX_TRANSMIT, 0);
        chk("mr_ack", TX_ACK, 0);
        chk("mr_busy", BUSY, 0);
        chk("mr_terr", TIMEOUT_ERR, 0);
        RST = 1'b0;
        spur = 0;
        repeat (5) begin tick(); if (TX_TRANSMIT) spur++; end
        chk("mr_no_load", spur, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
